// File: rtl/nvdla_cmac_pmac_core.sv
`default_nettype none
// ============================================================================
// Module   : nvdla_cmac_pmac_core
// Brief    : ATOMK x ATOMC signed dot-product MAC core with optional
//            saturating in-core stripe accumulation.
// Revision : 1.0
// ============================================================================
module nvdla_cmac_pmac_core #(
    parameter int ATOMC   = 8,
    parameter int ATOMK   = 4,
    parameter int BPE     = 8,
    parameter int PIPE    = 2,
    parameter int ACC_EXT = 4,
    parameter int RES_W   = 2*BPE + $clog2(ATOMC) + ACC_EXT
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   reg2dp_op_en,
    input  logic                   reg2dp_acc_en,
    input  logic                   sc2mac_dat_pvld,
    input  logic [ATOMC*BPE-1:0]   sc2mac_dat_data,
    input  logic [ATOMC-1:0]       sc2mac_dat_mask,
    input  logic [8:0]             sc2mac_dat_pd,
    input  logic                   sc2mac_wt_pvld,
    input  logic [ATOMC*BPE-1:0]   sc2mac_wt_data,
    input  logic [ATOMC-1:0]       sc2mac_wt_mask,
    input  logic [ATOMK-1:0]       sc2mac_wt_sel,
    output logic                   mac2accu_pvld,
    output logic [ATOMK-1:0]       mac2accu_mask,
    output logic [ATOMK*RES_W-1:0] mac2accu_data,
    output logic [8:0]             mac2accu_pd,
    output logic                   dp2reg_done
);
    localparam logic signed [RES_W-1:0] c_res_max = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic signed [RES_W-1:0] c_res_min = {1'b1, {(RES_W-1){1'b0}}};

    logic [ATOMC*BPE-1:0]    r_sh_wt  [ATOMK];
    logic [ATOMC-1:0]        r_sh_msk [ATOMK];
    logic [ATOMK-1:0]        r_sh_vld;
    logic [ATOMC*BPE-1:0]    r_ac_wt  [ATOMK];
    logic [ATOMC-1:0]        r_ac_msk [ATOMK];
    logic [ATOMK-1:0]        r_ac_vld;
    logic                    r_mode;

    logic                    r_in_vld;
    logic                    r_in_acc;
    logic [8:0]              r_in_pd;
    logic [ATOMK-1:0]        r_in_kmask;
    logic [ATOMC*BPE-1:0]    r_in_dat;
    logic [ATOMC*BPE-1:0]    r_in_wt [ATOMK];

    logic [PIPE-1:0]         r_st_vld;
    logic [PIPE-1:0]         r_st_acc;
    logic [8:0]              r_st_pd    [PIPE];
    logic [ATOMK-1:0]        r_st_kmask [PIPE];
    logic signed [RES_W-1:0] r_st_sum   [PIPE][ATOMK];

    logic signed [RES_W-1:0] r_acc [ATOMK];
    logic [ATOMK-1:0]        r_sat;
    logic                    r_acc_emit;
    logic [8:0]              r_acc_pd;
    logic [ATOMK-1:0]        r_acc_kmask;

    logic                    w_take_dat;
    logic                    w_take_wt;
    logic                    w_st;
    logic                    w_beat_acc;
    logic                    w_last_vld;
    logic                    w_last_acc;
    logic [8:0]              w_last_pd;
    logic [ATOMK-1:0]        w_sel_vld;
    logic [ATOMC*BPE-1:0]    w_src_wt;
    logic [ATOMC-1:0]        w_src_msk;
    logic [ATOMC*BPE-1:0]    w_in_dat;
    logic [ATOMC*BPE-1:0]    w_in_wt [ATOMK];
    logic signed [2*BPE-1:0] w_prod;
    logic signed [RES_W-1:0] w_dot [ATOMK];
    logic signed [RES_W:0]   w_sum [ATOMK];
    logic [ATOMK-1:0]        w_ovf;

    assign w_take_dat = reg2dp_op_en & sc2mac_dat_pvld;
    assign w_take_wt  = reg2dp_op_en & sc2mac_wt_pvld;
    assign w_st       = sc2mac_dat_pd[5];
    assign w_beat_acc = w_st ? reg2dp_acc_en : r_mode;
    assign w_last_vld = r_st_vld[PIPE-1];
    assign w_last_acc = r_st_acc[PIPE-1];
    assign w_last_pd  = r_st_pd[PIPE-1];

    // Shadow/active weight banks; a stripe_st copies shadow before the same-edge shadow write.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_sh_vld <= '0;
            r_ac_vld <= '0;
            for (int k = 0; k < ATOMK; k++) begin
                r_sh_wt[k]  <= '0;
                r_sh_msk[k] <= '0;
                r_ac_wt[k]  <= '0;
                r_ac_msk[k] <= '0;
            end
        end else if (dp2reg_done) begin
            r_sh_vld <= '0;
            r_ac_vld <= '0;
        end else begin
            if (w_take_dat && w_st) begin
                r_ac_vld <= r_sh_vld;
                for (int k = 0; k < ATOMK; k++) begin
                    r_ac_wt[k]  <= r_sh_wt[k];
                    r_ac_msk[k] <= r_sh_msk[k];
                end
            end
            if (w_take_wt) begin
                for (int k = 0; k < ATOMK; k++) begin
                    if (sc2mac_wt_sel[k]) begin
                        r_sh_wt[k]  <= sc2mac_wt_data;
                        r_sh_msk[k] <= sc2mac_wt_mask;
                        r_sh_vld[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Zero masked operands and inactive kernels so the tree needs no mask logic.
    always_comb begin
        w_sel_vld = w_st ? r_sh_vld : r_ac_vld;
        w_src_wt  = '0;
        w_src_msk = '0;
        for (int c = 0; c < ATOMC; c++)
            w_in_dat[c*BPE +: BPE] = sc2mac_dat_mask[c] ? sc2mac_dat_data[c*BPE +: BPE] : '0;
        for (int k = 0; k < ATOMK; k++) begin
            w_src_wt  = w_st ? r_sh_wt[k]  : r_ac_wt[k];
            w_src_msk = w_st ? r_sh_msk[k] : r_ac_msk[k];
            for (int c = 0; c < ATOMC; c++)
                w_in_wt[k][c*BPE +: BPE] = (w_sel_vld[k] && w_src_msk[c]) ? w_src_wt[c*BPE +: BPE] : '0;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_in_vld   <= 1'b0;
            r_in_acc   <= 1'b0;
            r_in_pd    <= '0;
            r_in_kmask <= '0;
            r_in_dat   <= '0;
            r_mode     <= 1'b0;
            for (int k = 0; k < ATOMK; k++) r_in_wt[k] <= '0;
        end else begin
            r_in_vld <= w_take_dat;
            if (w_take_dat) begin
                r_in_acc   <= w_beat_acc;
                r_in_pd    <= sc2mac_dat_pd;
                r_in_kmask <= w_sel_vld;
                r_in_dat   <= w_in_dat;
                for (int k = 0; k < ATOMK; k++) r_in_wt[k] <= w_in_wt[k];
                if (w_st) r_mode <= reg2dp_acc_en;
            end
        end
    end

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < ATOMK; k++) begin
            w_dot[k] = '0;
            for (int c = 0; c < ATOMC; c++) begin
                w_prod   = $signed(r_in_dat[c*BPE +: BPE]) * $signed(r_in_wt[k][c*BPE +: BPE]);
                w_dot[k] = w_dot[k] + RES_W'(w_prod);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_st_vld <= '0;
            r_st_acc <= '0;
            for (int i = 0; i < PIPE; i++) begin
                r_st_pd[i]    <= '0;
                r_st_kmask[i] <= '0;
                for (int k = 0; k < ATOMK; k++) r_st_sum[i][k] <= '0;
            end
        end else begin
            r_st_vld[0] <= r_in_vld;
            if (r_in_vld) begin
                r_st_acc[0]   <= r_in_acc;
                r_st_pd[0]    <= r_in_pd;
                r_st_kmask[0] <= r_in_kmask;
                for (int k = 0; k < ATOMK; k++) r_st_sum[0][k] <= w_dot[k];
            end
            for (int i = 1; i < PIPE; i++) begin
                r_st_vld[i] <= r_st_vld[i-1];
                if (r_st_vld[i-1]) begin
                    r_st_acc[i]   <= r_st_acc[i-1];
                    r_st_pd[i]    <= r_st_pd[i-1];
                    r_st_kmask[i] <= r_st_kmask[i-1];
                    for (int k = 0; k < ATOMK; k++) r_st_sum[i][k] <= r_st_sum[i-1][k];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ATOMK; k++) begin
            w_sum[k] = {r_acc[k][RES_W-1], r_acc[k]} + {r_st_sum[PIPE-1][k][RES_W-1], r_st_sum[PIPE-1][k]};
            w_ovf[k] = w_sum[k][RES_W] ^ w_sum[k][RES_W-1];
        end
    end

    // Once a lane saturates it holds the clamp value until the next stripe_st.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_acc_emit  <= 1'b0;
            r_acc_pd    <= '0;
            r_acc_kmask <= '0;
            r_sat       <= '0;
            for (int k = 0; k < ATOMK; k++) r_acc[k] <= '0;
        end else begin
            r_acc_emit <= w_last_vld & w_last_acc & w_last_pd[6];
            if (w_last_vld && w_last_acc) begin
                for (int k = 0; k < ATOMK; k++) begin
                    if (w_last_pd[5]) begin
                        r_acc[k] <= r_st_sum[PIPE-1][k];
                        r_sat[k] <= 1'b0;
                    end else if (!r_sat[k]) begin
                        if (w_ovf[k]) begin
                            r_acc[k] <= w_sum[k][RES_W] ? c_res_min : c_res_max;
                            r_sat[k] <= 1'b1;
                        end else begin
                            r_acc[k] <= w_sum[k][RES_W-1:0];
                        end
                    end
                end
                if (w_last_pd[6]) begin
                    r_acc_pd    <= w_last_pd;
                    r_acc_kmask <= r_st_kmask[PIPE-1];
                end
            end
        end
    end

    // An acc-mode emit takes the port if a non-acc beat lands in the same cycle.
    always_comb begin
        mac2accu_pvld = 1'b0;
        mac2accu_mask = '0;
        mac2accu_data = '0;
        mac2accu_pd   = '0;
        if (r_acc_emit) begin
            mac2accu_pvld = 1'b1;
            mac2accu_mask = r_acc_kmask;
            mac2accu_pd   = r_acc_pd;
            for (int k = 0; k < ATOMK; k++) mac2accu_data[k*RES_W +: RES_W] = r_acc[k];
        end else if (w_last_vld && !w_last_acc) begin
            mac2accu_pvld = 1'b1;
            mac2accu_mask = r_st_kmask[PIPE-1];
            mac2accu_pd   = w_last_pd;
            for (int k = 0; k < ATOMK; k++) mac2accu_data[k*RES_W +: RES_W] = r_st_sum[PIPE-1][k];
        end
    end

    assign dp2reg_done = mac2accu_pvld & mac2accu_pd[8];

endmodule
`default_nettype wire
